// File: rtl/kyber_pkg.sv
// Kyber arithmetic constants and coefficient/product types shared by the NTT butterfly stages.
package kyber_pkg;
  localparam int WIDTH = 12;
  localparam int IWID  = 24;
  localparam int Q     = 3329;
  localparam int BM    = 5039;
  localparam int BK    = 24;

  // Largest product two canonical residues can produce: (Q-1)^2.
  localparam int unsigned RANGE_MAX = (Q - 1) * (Q - 1);

  typedef logic [WIDTH-1:0] coeff_t;
  typedef logic [IWID-1:0]  prod_t;
endpackage

// File: rtl/mod_csub.sv
// Combinational conditional subtract of Q: y = (a >= Q) ? a - Q : a. Zero latency, no flow control.
module mod_csub #(
  parameter int          W = 14,
  parameter int unsigned Q = 3329
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = (a >= W'(Q)) ? a - W'(Q) : a;

endmodule

// File: rtl/barrett_reduce_pipe.sv
// 3-stage Barrett reducer (x mod Q) with tag sideband; RANGE_CHECK_EN adds a sticky out-of-range flag.
// Latency 3, 1/cycle; one shared enable stalls every stage while the output is held (in_ready = en).
module barrett_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  prod_t           in_x,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output coeff_t          out_r,
  output logic [TAGW-1:0] out_tag,
  output logic            range_err
);

  localparam int PW = IWID + 13;
  localparam int TW = PW - BK;
  localparam int RW = 14;

  logic            en;

  logic [PW-1:0]   p1_q, p1_d;
  prod_t           x1_q, x1_d;
  logic [TAGW-1:0] tag1_q, tag1_d;
  logic            v1_q, v1_d;

  logic [RW-1:0]   r2_q, r2_d;
  logic [TAGW-1:0] tag2_q, tag2_d;
  logic            v2_q, v2_d;

  coeff_t          out_r_q, out_r_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic            out_valid_q, out_valid_d;

  logic [TW-1:0]   t;
  logic [RW-1:0]   c0, c1;

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  mod_csub #(.W(RW), .Q(Q)) u_csub0 (.a(r2_q), .y(c0));
  mod_csub #(.W(RW), .Q(Q)) u_csub1 (.a(c0),   .y(c1));

  always_comb begin
    p1_d        = p1_q;
    x1_d        = x1_q;
    tag1_d      = tag1_q;
    v1_d        = v1_q;
    r2_d        = r2_q;
    tag2_d      = tag2_q;
    v2_d        = v2_q;
    out_r_d     = out_r_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    t           = p1_q[PW-1:BK];
    if (en) begin
      p1_d        = PW'(in_x) * PW'(BM);
      x1_d        = in_x;
      tag1_d      = in_tag;
      v1_d        = in_valid;
      // True remainder is below 3Q, so modulo-2^14 arithmetic is exact.
      r2_d        = RW'(x1_q) - RW'(t) * RW'(Q);
      tag2_d      = tag1_q;
      v2_d        = v1_q;
      out_r_d     = c1[WIDTH-1:0];
      out_tag_d   = tag2_q;
      out_valid_d = v2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q        <= '0;
      x1_q        <= '0;
      tag1_q      <= '0;
      v1_q        <= 1'b0;
      r2_q        <= '0;
      tag2_q      <= '0;
      v2_q        <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      x1_q        <= x1_d;
      tag1_q      <= tag1_d;
      v1_q        <= v1_d;
      r2_q        <= r2_d;
      tag2_q      <= tag2_d;
      v2_q        <= v2_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;

`ifdef RANGE_CHECK_EN
  logic range_err_q, range_err_d;

  always_comb begin
    range_err_d = range_err_q | (in_valid & in_ready & (in_x > prod_t'(RANGE_MAX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

  // Low product bits and the csub headroom bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{p1_q[BK-1:0], c1[RW-1:WIDTH]};

endmodule
